uart_tx_controller: RTL

Transmit sequencer for the UART TX path. It pops bytes from the 16-entry UART TX FIFO and serialises each one onto the TX line as an asynchronous frame: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It sits between the FIFO (fifoEmpty/fifoRe/dataOut) and the pad. It owns the FIFO read side exclusively.

---
 rtl/uart_tx_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: pops bytes from the TX FIFO and frames them as start, 8 data LSB-first, [parity], 1-2 stop bits.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN (ports are identical in both builds).
module uart_tx_controller #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 twoStopBits,
    input  logic [DIV_WIDTH-1:0] baudDivisor,
    input  logic                 parityOdd,
    input  logic                 fifoEmpty,
    input  logic [7:0]           fifoData,
    output logic                 fifoRe,
    output logic                 txd,
    output logic                 busy,
    output logic                 frameDone
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] baudCnt_q, baudCnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [2:0]           bitCnt_q, bitCnt_d;
    logic                 stopCnt_q, stopCnt_d;
    logic                 twoStop_q, twoStop_d;
    logic [7:0]           shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`else
    logic                 parity_unused;
    assign parity_unused = parityOdd;
`endif

    logic bitEnd;
    logic stopFinal;
    logic load;

    assign bitEnd    = (baudCnt_q == '0);
    assign stopFinal = (state_q == STOP) && bitEnd && (stopCnt_q || !twoStop_q);
    // Reset gates the pop so nothing leaves the FIFO while the sequencer is held.
    assign load      = reset & enable & ~fifoEmpty & ((state_q == IDLE) | stopFinal);

    assign fifoRe    = load;
    assign busy      = (state_q != IDLE);
    assign frameDone = stopFinal;

    always_comb begin
        txd = 1'b1;
        case (state_q)
            START:   txd = 1'b0;
            DATA:    txd = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd = parity_q;
`endif
            default: txd = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        div_d     = div_q;
        bitCnt_d  = bitCnt_q;
        stopCnt_d = stopCnt_q;
        twoStop_d = twoStop_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        if (state_q != IDLE) begin
            baudCnt_d = bitEnd ? div_q : (baudCnt_q - 1'b1);
        end

        case (state_q)
            START: begin
                if (bitEnd) begin
                    state_d  = DATA;
                    bitCnt_d = '0;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shift_d  = {1'b0, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                        stopCnt_d = 1'b0;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    state_d   = STOP;
                    stopCnt_d = 1'b0;
                end
            end
`endif
            STOP: begin
                if (bitEnd) begin
                    if (stopFinal) begin
                        state_d = IDLE;
                    end else begin
                        stopCnt_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A pop overrides the above so back-to-back frames skip IDLE entirely.
        if (load) begin
            state_d   = START;
            shift_d   = fifoData;
            div_d     = baudDivisor;
            baudCnt_d = baudDivisor;
            twoStop_d = twoStopBits;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^fifoData ^ parityOdd;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            stopCnt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitCnt_q  <= bitCnt_d;
            stopCnt_q <= stopCnt_d;
        end
    end

    always_ff @(posedge clock) begin
        div_q     <= div_d;
        twoStop_q <= twoStop_d;
        shift_q   <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q  <= parity_d;
`endif
    end

endmodule
